// File: rtl/hazard_scoreboard.sv
// Load-use hazard detection and forward-select generation for the instruction in ID.
// Tracks in-flight register writers across EX/MEM/WB in a 3-slot shift pipeline.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_reg_write,
  input  logic                id_is_load,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                hold,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [31:0]         busy_mask,
  output logic [STALL_CW-1:0] stall_cnt
);

  logic              ex_v, mem_v, wb_v;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_ld, mem_ld, wb_ld;

  logic       ex_a, ex_b, mem_a, mem_b;
  logic       enter_v;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // x0 never matches, so writes to x0 never cause a stall or a forward
  function automatic logic match(input logic v, input logic use_bit,
                                 input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rd);
    return v & use_bit & (rs != '0) & (rs == rd);
  endfunction

  assign ex_a  = match(ex_v,  id_use_rs1, id_rs1, ex_rd);
  assign ex_b  = match(ex_v,  id_use_rs2, id_rs2, ex_rd);
  assign mem_a = match(mem_v, id_use_rs1, id_rs1, mem_rd);
  assign mem_b = match(mem_v, id_use_rs2, id_rs2, mem_rd);

  assign stall   = id_valid & ~flush & ~hold & ex_ld & (ex_a | ex_b);
  assign enter_v = id_valid & id_reg_write & (id_rd != '0) & ~stall & ~flush;

  // Nearest producer wins; WB-slot matches fall back to the regfile
  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (id_valid & ~flush & ~stall) begin
      if (ex_a & ~ex_ld)  fwd_a_nxt = 2'b01;
      else if (mem_a)     fwd_a_nxt = 2'b10;
      if (ex_b & ~ex_ld)  fwd_b_nxt = 2'b01;
      else if (mem_b)     fwd_b_nxt = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v      <= 1'b0;
      ex_rd     <= '0;
      ex_ld     <= 1'b0;
      mem_v     <= 1'b0;
      mem_rd    <= '0;
      mem_ld    <= 1'b0;
      wb_v      <= 1'b0;
      wb_rd     <= '0;
      wb_ld     <= 1'b0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
    end else if (!hold) begin
      wb_v      <= mem_v;
      wb_rd     <= mem_rd;
      wb_ld     <= mem_ld;
      mem_v     <= ex_v;
      mem_rd    <= ex_rd;
      mem_ld    <= ex_ld;
      ex_v      <= enter_v;
      ex_rd     <= id_rd;
      ex_ld     <= id_is_load;
      fwd_a     <= fwd_a_nxt;
      fwd_b     <= fwd_b_nxt;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    busy_mask = 32'd0;
    if (ex_v)  busy_mask = busy_mask | (32'd1 << ex_rd);
    if (mem_v) busy_mask = busy_mask | (32'd1 << mem_rd);
    if (wb_v)  busy_mask = busy_mask | (32'd1 << wb_rd);
  end

  logic unused_wb_ld;
  assign unused_wb_ld = wb_ld;

endmodule
